// File: rtl/ahb_arb_pkg.sv
// Shared encodings for the AHB round-robin arbiter: htrans codes, FSM states
// and the default-master index.
package ahb_arb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] ARB_IDLE   = 2'b00;
   localparam logic [1:0] ARB_GRANT  = 2'b01;
   localparam logic [1:0] ARB_LOCKED = 2'b10;

   localparam int unsigned DEFAULT_MASTER = 0;

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first requester after 'last', wrapping, with 'last'
// itself checked final. Purely combinational.
module rr_pick #(
   parameter int unsigned NUM_MASTERS = 4,
   localparam int unsigned MW = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [MW-1:0]          last,
   output logic [NUM_MASTERS-1:0] winner,
   output logic [MW-1:0]          idx,
   output logic                   valid
);

   logic [MW-1:0] pos;

   always_comb begin
      winner = '0;
      idx    = '0;
      valid  = 1'b0;
      pos    = '0;
      for (int k = 1; k <= int'(NUM_MASTERS); k++) begin
         pos = MW'((int'(last) + k) % int'(NUM_MASTERS));
         if (!valid && req[pos]) begin
            valid       = 1'b1;
            idx         = pos;
            winner[pos] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter with lock and burst-continuity handling.
// Optional tenure limit enabled by defining ARB_TIMEOUT_EN.
module ahb_rr_arbiter
   import ahb_arb_pkg::*;
#(
   parameter int unsigned NUM_MASTERS = 4,
`ifdef ARB_TIMEOUT_EN
   parameter int unsigned MAX_TENURE = 16,
`endif
   localparam int unsigned MW = $clog2(NUM_MASTERS)
) (
   input  logic                   hclk,
   input  logic                   hresetn,
   input  logic [NUM_MASTERS-1:0] hbusreq,
   input  logic [NUM_MASTERS-1:0] hlock,
   input  logic [1:0]             htrans,
   input  logic                   hready,
   output logic [NUM_MASTERS-1:0] hgrant,
   output logic [MW-1:0]          hmaster,
   output logic                   hmastlock
);

   logic [1:0]             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d, grant_default;
   logic [MW-1:0]          last_q, last_d;
   logic [MW-1:0]          grant_idx;
   logic [NUM_MASTERS-1:0] req_eff;
   logic [NUM_MASTERS-1:0] pick_winner;
   logic [MW-1:0]          pick_idx;
   logic                   pick_valid;
   logic                   burst;
   logic                   lock_g;
   logic                   rearb;

   assign burst  = (htrans == HTRANS_BUSY) || (htrans == HTRANS_SEQ);
   assign lock_g = hlock[grant_idx];

   always_comb begin
      grant_default                 = '0;
      grant_default[DEFAULT_MASTER] = 1'b1;
   end

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < int'(NUM_MASTERS); i++) begin
         if (grant_q[i]) grant_idx = MW'(i);
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int unsigned TW = $clog2(MAX_TENURE + 1);

   logic [TW-1:0] tenure_q;
   logic          expired;

   // An owner that used up its tenure is hidden from the next pick; hold still wins.
   assign expired = (tenure_q == TW'(MAX_TENURE)) && (state_q != ARB_LOCKED);
   assign req_eff = expired ? (hbusreq & ~grant_q) : hbusreq;

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         tenure_q <= '0;
      end else if (hready) begin
         if (grant_d != grant_q) begin
            tenure_q <= '0;
         end else if (htrans[1] && (tenure_q != TW'(MAX_TENURE))) begin
            tenure_q <= tenure_q + 1'b1;
         end
      end
   end
`else
   assign req_eff = hbusreq;
`endif

   rr_pick #(
      .NUM_MASTERS (NUM_MASTERS)
   ) u_rr_pick (
      .req    (req_eff),
      .last   (last_q),
      .winner (pick_winner),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      rearb   = 1'b0;
      // A locked master also may not release in the middle of a burst.
      if (hready && !burst) begin
         unique case (state_q)
            ARB_IDLE:   rearb = 1'b1;
            ARB_GRANT: begin
               if (lock_g) state_d = ARB_LOCKED;
               else        rearb   = 1'b1;
            end
            ARB_LOCKED: rearb = !lock_g;
            default:    state_d = ARB_IDLE;
         endcase
      end
      if (rearb) begin
         if (pick_valid) begin
            grant_d = pick_winner;
            last_d  = pick_idx;
            state_d = ARB_GRANT;
         end else begin
            grant_d = grant_default;
            state_d = ARB_IDLE;
         end
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_q   <= ARB_IDLE;
         grant_q   <= NUM_MASTERS'(1);
         last_q    <= '0;
         hmaster   <= '0;
         hmastlock <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         if (hready) begin
            hmaster   <= grant_idx;
            hmastlock <= lock_g;
         end
      end
   end

   assign hgrant = grant_q;

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Directed self-checking bench for ahb_rr_arbiter (default build, 4 masters).
module tb_ahb_rr_arbiter;

   logic       hclk = 1'b0;
   logic       hresetn;
   logic [3:0] hbusreq;
   logic [3:0] hlock;
   logic [1:0] htrans;
   logic       hready;
   logic [3:0] hgrant;
   logic [1:0] hmaster;
   logic       hmastlock;

   int n_checks = 0;
   int n_errors = 0;

   always #5 hclk = ~hclk;

   ahb_rr_arbiter #(
      .NUM_MASTERS (4)
   ) dut (
      .hclk      (hclk),
      .hresetn   (hresetn),
      .hbusreq   (hbusreq),
      .hlock     (hlock),
      .htrans    (htrans),
      .hready    (hready),
      .hgrant    (hgrant),
      .hmaster   (hmaster),
      .hmastlock (hmastlock)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [3:0] g, input logic [1:0] m,
                            input logic l);
      check({tag, ".hgrant"}, 32'(hgrant), 32'(g));
      check({tag, ".hmaster"}, 32'(hmaster), 32'(m));
      check({tag, ".hmastlock"}, 32'(hmastlock), 32'(l));
   endtask

   logic [3:0] rot_g [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
   logic [1:0] rot_m [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
   logic [3:0] wait_req [5] = '{4'b0001, 4'b1010, 4'b0110, 4'b1111, 4'b0000};

   initial begin
      hresetn = 1'b0;
      hbusreq = '0;
      hlock   = '0;
      htrans  = 2'b00;
      hready  = 1'b1;
      #12;
      check_out("reset", 4'b0001, 2'd0, 1'b0);
      hresetn = 1'b1;
      step();
      step();
      check_out("idle_after_reset", 4'b0001, 2'd0, 1'b0);

      // Rotation with all masters requesting
      hbusreq = 4'b1111;
      htrans  = 2'b10;
      for (int i = 0; i < 5; i++) begin
         step();
         check_out($sformatf("rotate%0d", i), rot_g[i], rot_m[i], 1'b0);
      end

      // Burst hold on master 2
      step();
      check_out("to_m2", 4'b0100, 2'd1, 1'b0);
      htrans = 2'b11;
      for (int i = 0; i < 3; i++) begin
         step();
         check_out($sformatf("burst%0d", i), 4'b0100, 2'd2, 1'b0);
      end
      htrans = 2'b10;
      step();
      check_out("burst_end", 4'b1000, 2'd2, 1'b0);

      // Wait states freeze everything
      hready = 1'b0;
      hlock  = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         hbusreq = wait_req[i];
         step();
         check_out($sformatf("wait%0d", i), 4'b1000, 2'd2, 1'b0);
      end
      hready  = 1'b1;
      hlock   = 4'b0000;
      hbusreq = 4'b1111;

      // Lock held by master 1; lock on master 3 (not granted) ignored
      step();
      check_out("pre_lock0", 4'b0001, 2'd3, 1'b0);
      step();
      check_out("pre_lock1", 4'b0010, 2'd0, 1'b0);
      hlock = 4'b0010;
      step();
      check_out("lock0", 4'b0010, 2'd1, 1'b1);
      hlock = 4'b1010;
      step();
      step();
      check_out("lock2", 4'b0010, 2'd1, 1'b1);
      hlock = 4'b0000;
      step();
      check_out("unlock", 4'b0100, 2'd1, 1'b0);

      // Sole requester re-granted to itself
      hbusreq = 4'b0100;
      step();
      check_out("sole0", 4'b0100, 2'd2, 1'b0);
      step();
      check_out("sole1", 4'b0100, 2'd2, 1'b0);

      // Dropped request keeps grant until the next arbitration point
      hbusreq = 4'b0000;
      htrans  = 2'b11;
      step();
      check_out("drop_hold", 4'b0100, 2'd2, 1'b0);
      htrans = 2'b00;
      step();
      check_out("drop_default", 4'b0001, 2'd2, 1'b0);

      // Asynchronous reset in the middle of a locked burst
      hbusreq = 4'b1111;
      htrans  = 2'b10;
      step();
      check_out("pre_rst", 4'b1000, 2'd0, 1'b0);
      htrans = 2'b11;
      hlock  = 4'b1000;
      step();
      check_out("mid_burst", 4'b1000, 2'd3, 1'b1);
      #2;
      hresetn = 1'b0;
      #1;
      check_out("async_rst", 4'b0001, 2'd0, 1'b0);
      #2;
      hresetn = 1'b1;
      hlock   = 4'b0000;
      htrans  = 2'b10;
      step();
      check_out("post_rst", 4'b0010, 2'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
